// File: rtl/selector_banda_ps2_if.sv
// selector_banda_ps2_if: PS/2 byte input and band/gain command outputs
interface selector_banda_ps2_if #(
    parameter int GAIN_W = 4
);
    logic [7:0]        rx_data;
    logic              rx_done_tick;
    logic [1:0]        sel;
    logic [GAIN_W-1:0] gain_t;
    logic [GAIN_W-1:0] gain_b;
    logic [GAIN_W-1:0] gain_m;
    logic [GAIN_W-1:0] gain_a;
    logic              cmd_tick;

    modport master (
        output rx_data, rx_done_tick,
        input  sel, gain_t, gain_b, gain_m, gain_a, cmd_tick
    );

    modport slave (
        input  rx_data, rx_done_tick,
        output sel, gain_t, gain_b, gain_m, gain_a, cmd_tick
    );
endinterface

// File: rtl/selector_banda_ps2.sv
// selector_banda_ps2: PS/2 scancode decoder driving band select and per-band gains
module selector_banda_ps2 #(
    parameter int GAIN_W     = 4,
    parameter int GAIN_RESET = 8,
    parameter int GAIN_MAX   = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    selector_banda_ps2_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    localparam logic [GAIN_W-1:0] L_GRST = GAIN_W'(GAIN_RESET);
    localparam logic [GAIN_W-1:0] L_GMAX = GAIN_W'(GAIN_MAX);

    state_t            r_state, w_state_nxt;
    logic              r_held_valid, w_held_valid_nxt;
    logic              r_held_ext, w_held_ext_nxt;
    logic [7:0]        r_held_code, w_held_code_nxt;
    logic [1:0]        r_sel, w_sel_nxt;
    logic [GAIN_W-1:0] r_gain [4];
    logic [GAIN_W-1:0] w_gain_nxt [4];
    logic [GAIN_W-1:0] w_cur;
    logic              r_cmd_tick, w_changed;
    logic              w_make, w_brk, w_ext, w_match, w_accept;

    // Register prefix state, held key, band select, gains and change pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_held_valid <= 1'b0;
            r_held_ext   <= 1'b0;
            r_held_code  <= 8'h00;
            r_sel        <= 2'b00;
            r_cmd_tick   <= 1'b0;
            for (int i = 0; i < 4; i++) r_gain[i] <= L_GRST;
        end else begin
            r_state      <= w_state_nxt;
            r_held_valid <= w_held_valid_nxt;
            r_held_ext   <= w_held_ext_nxt;
            r_held_code  <= w_held_code_nxt;
            r_sel        <= w_sel_nxt;
            r_cmd_tick   <= w_changed;
            for (int i = 0; i < 4; i++) r_gain[i] <= w_gain_nxt[i];
        end
    end

    // Decode prefixes into make/break events, filter repeats, compute actions
    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_brk       = 1'b0;
        w_ext       = 1'b0;
        if (bus.rx_done_tick) begin
            case (r_state)
                IDLE: begin
                    if (bus.rx_data == 8'hE0) w_state_nxt = EXT;
                    else if (bus.rx_data == 8'hF0) w_state_nxt = BRK;
                    else w_make = (bus.rx_data != 8'hFA) && (bus.rx_data != 8'hAA);
                end
                EXT: begin
                    if (bus.rx_data == 8'hF0) w_state_nxt = EXT_BRK;
                    else if (bus.rx_data != 8'hE0) begin
                        w_make      = 1'b1;
                        w_ext       = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                BRK: begin
                    if (bus.rx_data != 8'hF0 && bus.rx_data != 8'hE0) begin
                        w_brk       = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_brk       = 1'b1;
                    w_ext       = 1'b1;
                    w_state_nxt = IDLE;
                end
            endcase
        end
        w_match          = r_held_valid && (r_held_ext == w_ext) && (r_held_code == bus.rx_data);
        w_accept         = w_make && !w_match;
        w_held_valid_nxt = w_accept ? 1'b1 : (w_brk && w_match) ? 1'b0 : r_held_valid;
        w_held_ext_nxt   = w_accept ? w_ext : r_held_ext;
        w_held_code_nxt  = w_accept ? bus.rx_data : r_held_code;
        w_sel_nxt        = r_sel;
        for (int i = 0; i < 4; i++) w_gain_nxt[i] = r_gain[i];
        w_cur = r_gain[r_sel];
        if (w_accept && !w_ext) begin
            case (bus.rx_data)
                8'h2C: w_sel_nxt = 2'b00;
                8'h32: w_sel_nxt = 2'b01;
                8'h3A: w_sel_nxt = 2'b10;
                8'h1C: w_sel_nxt = 2'b11;
                8'h2D: for (int i = 0; i < 4; i++) w_gain_nxt[i] = L_GRST;
                default: ;
            endcase
        end
        if (w_accept && w_ext && bus.rx_data == 8'h75)
            w_gain_nxt[r_sel] = (w_cur >= L_GMAX) ? w_cur : w_cur + 1'b1;
        if (w_accept && w_ext && bus.rx_data == 8'h72)
            w_gain_nxt[r_sel] = (w_cur == '0) ? w_cur : w_cur - 1'b1;
        w_changed = (w_sel_nxt != r_sel);
        for (int i = 0; i < 4; i++) w_changed = w_changed || (w_gain_nxt[i] != r_gain[i]);
    end

    assign bus.sel      = r_sel;
    assign bus.gain_t   = r_gain[0];
    assign bus.gain_b   = r_gain[1];
    assign bus.gain_m   = r_gain[2];
    assign bus.gain_a   = r_gain[3];
    assign bus.cmd_tick = r_cmd_tick;
endmodule

// File: tb/tb_selector_banda_ps2.sv
// tb_selector_banda_ps2: table-driven scancode sequences with a result scoreboard
module tb_selector_banda_ps2;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_ticks = 0;
    int   checks = 0;
    int   errors = 0;

    selector_banda_ps2_if #(.GAIN_W(4)) ifc ();

    selector_banda_ps2 #(.GAIN_W(4), .GAIN_RESET(8), .GAIN_MAX(15)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (reset_n && ifc.cmd_tick) n_ticks++;

    typedef struct {
        int         nb;
        logic [7:0] b [5];
        logic [1:0] sel;
        logic [15:0] g;
        int         ticks;
    } vec_t;

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] g;
        int          ticks;
    } exp_t;

    vec_t vq [$];
    exp_t exp_q [$];

    function automatic void add(int nb, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                                logic [7:0] b3, logic [7:0] b4, logic [1:0] s,
                                logic [3:0] t, logic [3:0] bb, logic [3:0] m, logic [3:0] a, int tk);
        vec_t v;
        v.nb = nb;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
        v.sel = s;
        v.g = {t, bb, m, a};
        v.ticks = tk;
        vq.push_back(v);
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec%0d got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic run_vec(vec_t v, int idx);
        exp_t e;
        int   t0;
        t0 = n_ticks;
        e.sel = v.sel; e.g = v.g; e.ticks = v.ticks;
        exp_q.push_back(e);
        for (int k = 0; k < v.nb; k++) begin
            @(negedge clk);
            ifc.rx_data = v.b[k];
            ifc.rx_done_tick = 1'b1;
        end
        @(negedge clk);
        ifc.rx_done_tick = 1'b0;
        ifc.rx_data = 8'h55;
        repeat (2) @(negedge clk);
        #1;
        e = exp_q.pop_front();
        chk("sel", idx, 32'(ifc.sel), 32'(e.sel));
        chk("gains", idx, 32'({ifc.gain_t, ifc.gain_b, ifc.gain_m, ifc.gain_a}), 32'(e.g));
        chk("cmd_ticks", idx, 32'(n_ticks - t0), 32'(e.ticks));
    endtask

    task automatic chk_reset_state(int idx);
        chk("rst_sel", idx, 32'(ifc.sel), 32'd0);
        chk("rst_gains", idx, 32'({ifc.gain_t, ifc.gain_b, ifc.gain_m, ifc.gain_a}), 32'h8888);
        chk("rst_tick", idx, 32'(ifc.cmd_tick), 32'd0);
    endtask

    initial begin
        vec_t v;
        int   t0;
        ifc.rx_data = 8'h00;
        ifc.rx_done_tick = 1'b0;
        add(1, 8'h32, 0, 0, 0, 0, 2'd1, 8, 8, 8, 8, 1);
        add(2, 8'hF0, 8'h32, 0, 0, 0, 2'd1, 8, 8, 8, 8, 0);
        add(1, 8'h3A, 0, 0, 0, 0, 2'd2, 8, 8, 8, 8, 1);
        add(1, 8'h1C, 0, 0, 0, 0, 2'd3, 8, 8, 8, 8, 1);
        add(3, 8'h32, 8'h32, 8'h32, 0, 0, 2'd1, 8, 8, 8, 8, 1);
        add(2, 8'hF0, 8'h32, 0, 0, 0, 2'd1, 8, 8, 8, 8, 0);
        add(1, 8'h32, 0, 0, 0, 0, 2'd1, 8, 8, 8, 8, 0);
        add(2, 8'hF0, 8'h32, 0, 0, 0, 2'd1, 8, 8, 8, 8, 0);
        add(1, 8'h2C, 0, 0, 0, 0, 2'd0, 8, 8, 8, 8, 1);
        add(2, 8'hF0, 8'h2C, 0, 0, 0, 2'd0, 8, 8, 8, 8, 0);
        for (int i = 0; i < 8; i++)
            add(5, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 2'd0, (i < 7) ? 4'(9 + i) : 4'd15, 8, 8, 8, (i < 7) ? 1 : 0);
        for (int i = 0; i < 16; i++)
            add(5, 8'hE0, 8'h72, 8'hE0, 8'hF0, 8'h72, 2'd0, (i < 15) ? 4'(14 - i) : 4'd0, 8, 8, 8, (i < 15) ? 1 : 0);
        add(1, 8'h75, 0, 0, 0, 0, 2'd0, 0, 8, 8, 8, 0);
        add(2, 8'hF0, 8'h75, 0, 0, 0, 2'd0, 0, 8, 8, 8, 0);
        add(3, 8'hE0, 8'hE0, 8'h75, 0, 0, 2'd0, 1, 8, 8, 8, 1);
        add(3, 8'hE0, 8'hF0, 8'h75, 0, 0, 2'd0, 1, 8, 8, 8, 0);
        add(3, 8'hF0, 8'hF0, 8'h2C, 0, 0, 2'd0, 1, 8, 8, 8, 0);
        add(1, 8'hFA, 0, 0, 0, 0, 2'd0, 1, 8, 8, 8, 0);
        add(1, 8'hAA, 0, 0, 0, 0, 2'd0, 1, 8, 8, 8, 0);
        add(2, 8'hE0, 8'h2C, 0, 0, 0, 2'd0, 1, 8, 8, 8, 0);
        add(3, 8'hE0, 8'hF0, 8'h2C, 0, 0, 2'd0, 1, 8, 8, 8, 0);
        add(1, 8'h32, 0, 0, 0, 0, 2'd1, 1, 8, 8, 8, 1);
        add(2, 8'hF0, 8'h32, 0, 0, 0, 2'd1, 1, 8, 8, 8, 0);
        for (int i = 0; i < 5; i++)
            add(5, 8'hE0, 8'h72, 8'hE0, 8'hF0, 8'h72, 2'd1, 1, 4'(7 - i), 8, 8, 1);
        add(1, 8'h2D, 0, 0, 0, 0, 2'd1, 8, 8, 8, 8, 1);
        add(2, 8'hF0, 8'h2D, 0, 0, 0, 2'd1, 8, 8, 8, 8, 0);

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk_reset_state(-1);
        t0 = n_ticks;
        ifc.rx_data = 8'h32;
        repeat (4) @(negedge clk);
        ifc.rx_data = 8'h1C;
        repeat (2) @(negedge clk);
        #1;
        chk("idle_sel", -2, 32'(ifc.sel), 32'd0);
        chk("idle_ticks", -2, 32'(n_ticks - t0), 32'd0);

        foreach (vq[i]) run_vec(vq[i], i);

        v.nb = 1; v.b[0] = 8'hE0; v.sel = 2'd1; v.g = 16'h8888; v.ticks = 0;
        run_vec(v, 100);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_reset_state(101);
        v.nb = 1; v.b[0] = 8'h75; v.sel = 2'd0; v.g = 16'h8888; v.ticks = 0;
        run_vec(v, 102);
        v.nb = 2; v.b[0] = 8'hE0; v.b[1] = 8'h75; v.sel = 2'd0; v.g = 16'h9888; v.ticks = 1;
        run_vec(v, 103);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
